alarm_ring_ctrl: RTL and testbench
==================================

Name: alarm_ring_ctrl

Overview:
- Consumes the seconds-of-day counters from the timekeeping/alarm-set stage: current time `count` and alarm time `count_alarm`.
- Decides when the alarm sounds and drives a buzzer-enable level and status LEDs.
- Handles stop, snooze with a snooze limit, auto-timeout and a missed-alarm indicator.
- Runs on the same 1 Hz clock as the timekeeping stage; one clock cycle equals one second.

Parameters:
- RING_SECS, 60, seconds a ring lasts before auto-timeout (1..65535)
- SNOOZE_SECS, 300, seconds spent in snooze before re-ringing (1..65535)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0..15)

Ports:
- clk_1hz  input  1  system clock, one edge per second
- rst  input  1  synchronous, active-high reset
- count  input  21  current time, seconds of day, 0..86400
- count_alarm  input  21  alarm time, seconds of day, 0..86400
- alarm_en  input  1  alarm-set mode active; suppresses new triggers
- alarm_arm  input  1  alarm armed (user switch)
- stop_btn  input  1  stop request, level, sampled on clk_1hz
- snooze_btn  input  1  snooze request, level, sampled on clk_1hz
- buzzer  output  1  buzzer enable level (tone is generated elsewhere)
- ringing  output  1  high in RINGING state
- snoozing  output  1  high in SNOOZE state
- missed_led  output  1  sticky: the last alarm timed out unanswered
- snooze_left  output  4  snoozes remaining in the current event

Behaviour:
- Interface: one clock, clk_1hz; reset rst is synchronous and active-high.
- Reset values: state=IDLE, buzzer=0, ringing=0, snoozing=0, missed_led=0, snooze_left=MAX_SNOOZE, internal timer=0, match_seen=0.
- Normalisation: an input value of 86400 on either count or count_alarm is treated as 0 for comparison.
- match = (norm(count) == norm(count_alarm)).
- match_seen register:
  - Set on any edge where match=1.
  - Cleared on any edge where match=0.
  - Purpose: a held or locked count cannot retrigger.
- trigger = match & ~match_seen & alarm_arm & ~alarm_en.
- Latency: the block registers count as presented at the edge; state changes at that same edge. Buzzer rises on the first edge where count equals count_alarm.
- States are IDLE, RINGING and SNOOZE.
- IDLE:
  - On trigger: go to RINGING, timer=0, buzzer=1, snooze_left=MAX_SNOOZE.
- RINGING:
  - buzzer toggles every edge: 1,0,1,0… starting at 1 on entry.
  - timer increments each edge.
  - Priority 1: rst.
  - Priority 2: stop_btn=1 or alarm_arm=0 → IDLE, buzzer=0, missed_led=0.
  - Priority 3: snooze_btn=1 and snooze_left>0 → SNOOZE, timer=0, snooze_left−1, buzzer=0.
  - snooze_btn with snooze_left=0 is ignored; ringing continues.
  - Priority 4: timer reaches RING_SECS−1 → IDLE, buzzer=0, missed_led=1.
- SNOOZE:
  - buzzer=0; timer increments each edge.
  - stop_btn=1 or alarm_arm=0 → IDLE, missed_led=0.
  - timer reaches SNOOZE_SECS−1 → RINGING, timer=0, buzzer=1.
  - snooze_btn is ignored.
- missed_led:
  - Cleared by stop_btn in any state, or by rst.
  - Set only by timeout.
- In RINGING or SNOOZE, a new trigger is ignored; a single event is in progress.
- alarm_en=1 does not cancel an active ring or snooze; it only blocks new triggers.
- Clock edits (count jumping by 60 or 3600):
  - Landing exactly on count_alarm triggers like normal counting.
  - Skipping past it does not trigger.
- rst mid-ring or mid-snooze: all outputs return to reset values on that edge.
- Timer is 16 bits; it never wraps because exits occur at the parameter limit.

Optional Feature:
- Macro: ALARM_HOURLY_CHIME_EN.
- Defined:
  - In IDLE with alarm_arm=1 and alarm_en=0, an edge where norm(count) mod 3600 == 0 and count differs from the previous sampled value asserts buzzer for exactly 1 cycle.
  - A chime coinciding with an alarm trigger is superseded by RINGING.
  - The chime never changes state or missed_led.
- Not defined:
  - No chime logic is present.
  - buzzer is driven only by RINGING.

Test Plan:
- count_alarm=3600, arm=1, count stepped 3598→3601 → buzzer=1 and ringing=1 at the edge presenting 3600; buzzer pattern 1,0,1,0.
- Ringing, snooze_btn pulsed once → snoozing=1, snooze_left=2, buzzer=0; after SNOOZE_SECS cycles ringing=1 again, buzzer=1.
- MAX_SNOOZE=3: snooze three times, then a fourth snooze_btn → ignored, ringing stays 1, snooze_left=0; stop_btn → IDLE, all outputs 0.
- No button for RING_SECS=60 cycles → cycle 60 ringing=0, missed_led=1; next trigger then stop_btn clears missed_led.
- count held at 3600 (locked) for 10 cycles with arm=1 → exactly one trigger; alarm_en=1 at match → no trigger; count jumping 3540→3600 by minute edit → triggers; count_alarm=86400 with count=0 → triggers.
- rst asserted mid-RINGING → next edge all outputs at reset values. With ALARM_HOURLY_CHIME_EN: count 7199→7200 in IDLE → buzzer high exactly 1 cycle, state stays IDLE.

Source files
------------

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller on the 1 Hz timekeeping clock: trigger detection, ring/snooze FSM,
// auto-timeout and missed-alarm LED. Optional hourly chime via `ALARM_HOURLY_CHIME_EN.
module alarm_ring_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int MAX_SNOOZE  = 3
) (
  input  logic        clk_1hz,
  input  logic        rst,
  input  logic [20:0] count,
  input  logic [20:0] count_alarm,
  input  logic        alarm_en,
  input  logic        alarm_arm,
  input  logic        stop_btn,
  input  logic        snooze_btn,
  output logic        buzzer,
  output logic        ringing,
  output logic        snoozing,
  output logic        missed_led,
  output logic [3:0]  snooze_left
);

  localparam logic [20:0] DAY_SECS    = 21'd86400;
  localparam logic [15:0] RING_LAST   = 16'(RING_SECS - 1);
  localparam logic [15:0] SNOOZE_LAST = 16'(SNOOZE_SECS - 1);
  localparam logic [3:0]  SNOOZE_MAX  = 4'(MAX_SNOOZE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        buzzer_q, buzzer_d;
  logic        missed_q, missed_d;
  logic [3:0]  snooze_left_q, snooze_left_d;
  logic        match_seen_q, match_seen_d;

  logic [20:0] count_n;
  logic [20:0] alarm_n;
  logic        match;
  logic        trigger;
  logic        chime;

  // 86400 is the end-of-day alias of midnight.
  assign count_n = (count == DAY_SECS) ? 21'd0 : count;
  assign alarm_n = (count_alarm == DAY_SECS) ? 21'd0 : count_alarm;
  assign match   = (count_n == alarm_n);
  assign trigger = match & ~match_seen_q & alarm_arm & ~alarm_en;

`ifdef ALARM_HOURLY_CHIME_EN
  logic [20:0] prev_count_q;

  always_ff @(posedge clk_1hz) begin
    if (rst) prev_count_q <= 21'd0;
    else     prev_count_q <= count;
  end

  // A held count on the hour chimes only once.
  assign chime = ((count_n % 21'd3600) == 21'd0) && (count != prev_count_q);
`else
  assign chime = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    buzzer_d      = 1'b0;
    missed_d      = missed_q;
    snooze_left_d = snooze_left_q;
    match_seen_d  = match;

    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d       = ST_RINGING;
          timer_d       = 16'd0;
          buzzer_d      = 1'b1;
          snooze_left_d = SNOOZE_MAX;
        end else if (chime && alarm_arm && !alarm_en) begin
          buzzer_d = 1'b1;
        end
      end

      ST_RINGING: begin
        timer_d = timer_q + 16'd1;
        if (stop_btn || !alarm_arm) begin
          state_d = ST_IDLE;
          timer_d = 16'd0;
        end else if (snooze_btn && (snooze_left_q != 4'd0)) begin
          state_d       = ST_SNOOZE;
          timer_d       = 16'd0;
          snooze_left_d = snooze_left_q - 4'd1;
        end else if (timer_q == RING_LAST) begin
          state_d  = ST_IDLE;
          timer_d  = 16'd0;
          missed_d = 1'b1;
        end else begin
          buzzer_d = ~buzzer_q;
        end
      end

      ST_SNOOZE: begin
        timer_d = timer_q + 16'd1;
        if (stop_btn || !alarm_arm) begin
          state_d = ST_IDLE;
          timer_d = 16'd0;
        end else if (timer_q == SNOOZE_LAST) begin
          state_d  = ST_RINGING;
          timer_d  = 16'd0;
          buzzer_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        timer_d = 16'd0;
      end
    endcase

    // An answered or cancelled event is no longer "missed".
    if (stop_btn || ((state_q != ST_IDLE) && !alarm_arm)) missed_d = 1'b0;
  end

  always_ff @(posedge clk_1hz) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      timer_q       <= 16'd0;
      buzzer_q      <= 1'b0;
      missed_q      <= 1'b0;
      snooze_left_q <= SNOOZE_MAX;
      match_seen_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      buzzer_q      <= buzzer_d;
      missed_q      <= missed_d;
      snooze_left_q <= snooze_left_d;
      match_seen_q  <= match_seen_d;
    end
  end

  assign buzzer      = buzzer_q;
  assign ringing     = (state_q == ST_RINGING);
  assign snoozing    = (state_q == ST_SNOOZE);
  assign missed_led  = missed_q;
  assign snooze_left = snooze_left_q;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl: directed scenarios plus random traffic, each cycle
// checked against an event-level reference model of the alarm behaviour.
module tb_alarm_ring_ctrl;

  localparam int RING = 12;
  localparam int SNZ  = 7;
  localparam int MAXS = 3;

  logic        clk_1hz = 1'b0;
  logic        rst = 1'b1;
  logic [20:0] count = '0;
  logic [20:0] count_alarm = '0;
  logic        alarm_en = 1'b0;
  logic        alarm_arm = 1'b0;
  logic        stop_btn = 1'b0;
  logic        snooze_btn = 1'b0;
  logic        buzzer, ringing, snoozing, missed_led;
  logic [3:0]  snooze_left;

  alarm_ring_ctrl #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
    .clk_1hz(clk_1hz), .rst(rst), .count(count), .count_alarm(count_alarm),
    .alarm_en(alarm_en), .alarm_arm(alarm_arm), .stop_btn(stop_btn),
    .snooze_btn(snooze_btn), .buzzer(buzzer), .ringing(ringing),
    .snoozing(snoozing), .missed_led(missed_led), .snooze_left(snooze_left)
  );

  always #5 clk_1hz = ~clk_1hz;

  // Scoreboard: {buzzer, ringing, snoozing, missed_led, snooze_left}
  logic [7:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: mode 0 idle, 1 ringing, 2 snoozing; age counts seconds in the mode.
  int m_mode = 0, m_age = 0, m_left = MAXS;
  bit m_missed = 0, m_seen = 0, m_chime = 0;
  int m_prev = 0;

  function automatic int norm(input int v);
    return (v == 86400) ? 0 : v;
  endfunction

  function automatic void model_step(input bit r, input int c, input int a, input bit en,
                                     input bit arm, input bit stp, input bit snz);
    bit hit, trig;
    m_chime = 0;
    if (r) begin
      m_mode = 0; m_age = 0; m_left = MAXS; m_missed = 0; m_seen = 0; m_prev = 0;
      return;
    end
    hit  = (norm(c) == norm(a));
    trig = hit && !m_seen && arm && !en;
    if (m_mode == 0) begin
      if (trig) begin
        m_mode = 1; m_age = 0; m_left = MAXS;
      end else begin
`ifdef ALARM_HOURLY_CHIME_EN
        m_chime = arm && !en && (norm(c) % 3600 == 0) && (c != m_prev);
`endif
      end
    end else if (m_mode == 1) begin
      if (stp || !arm) begin
        m_mode = 0; m_missed = 0;
      end else if (snz && m_left > 0) begin
        m_mode = 2; m_age = 0; m_left = m_left - 1;
      end else if (m_age == RING - 1) begin
        m_mode = 0; m_missed = 1;
      end else begin
        m_age = m_age + 1;
      end
    end else begin
      if (stp || !arm) begin
        m_mode = 0; m_missed = 0;
      end else if (m_age == SNZ - 1) begin
        m_mode = 1; m_age = 0;
      end else begin
        m_age = m_age + 1;
      end
    end
    if (stp) m_missed = 0;
    m_seen = hit;
    m_prev = c;
  endfunction

  function automatic logic [7:0] model_out();
    bit buz;
    buz = ((m_mode == 1) && (m_age % 2 == 0)) || m_chime;
    return {buz, m_mode == 1, m_mode == 2, m_missed, 4'(m_left)};
  endfunction

  task automatic drive(input bit r, input int c, input int a, input bit en, input bit arm,
                       input bit stp, input bit snz);
    @(negedge clk_1hz);
    rst = r; count = 21'(c); count_alarm = 21'(a);
    alarm_en = en; alarm_arm = arm; stop_btn = stp; snooze_btn = snz;
    model_step(r, c, a, en, arm, stp, snz);
    exp_q.push_back(model_out());
  endtask

  // Monitor: one DUT result per clock, compared with the oldest expectation.
  initial begin
    logic [7:0] got, exp;
    forever begin
      @(posedge clk_1hz);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        exp = exp_q.pop_front();
        got = {buzzer, ringing, snoozing, missed_led, snooze_left};
        total++;
        if (got !== exp) begin
          bad++;
          $display("FAIL outputs cyc=%0d count=%0d {buz,ring,snz,missed,left} got=%b exp=%b",
                   cyc, count, got, exp);
        end
      end
    end
  end

  int cnt = 0;
  int cur_alarm = 0;
  bit cur_en = 0;
  bit cur_arm = 1;

  task automatic tick(input bit stp, input bit snz);
    drive(1'b0, cnt, cur_alarm, cur_en, cur_arm, stp, snz);
    cnt = (cnt >= 86399) ? 0 : cnt + 1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  initial begin
    // Reset values
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Trigger at 3600, ring pattern, snoozes until exhausted, then stop
    cur_alarm = 3600; cur_arm = 1; cur_en = 0; cnt = 3598;
    ticks(6);
    tick(1'b0, 1'b1);
    ticks(SNZ + 2);
    tick(1'b0, 1'b1);
    ticks(SNZ + 2);
    tick(1'b0, 1'b1);
    ticks(SNZ + 2);
    tick(1'b0, 1'b1);
    ticks(2);
    tick(1'b1, 1'b0);
    ticks(2);

    // Unanswered ring times out; next event stopped clears missed_led
    cur_alarm = cnt + 2;
    ticks(RING + 5);
    cur_alarm = cnt + 2;
    ticks(4);
    tick(1'b1, 1'b0);
    ticks(2);

    // Locked count at the alarm time triggers once
    cur_alarm = cnt + 2;
    ticks(2);
    for (int i = 0; i < 10; i++) drive(1'b0, cnt, cur_alarm, 1'b0, 1'b1, i == 3, 1'b0);
    ticks(2);

    // Alarm-set mode blocks the trigger
    cur_alarm = cnt + 2; cur_en = 1;
    ticks(4);
    cur_en = 0;

    // Minute edit landing on the alarm
    cur_alarm = 3600; cnt = 3540;
    ticks(1);
    cnt = 3600;
    ticks(3);
    tick(1'b1, 1'b0);

    // 86400 alarm matches midnight
    cur_alarm = 86400; cnt = 86398;
    ticks(4);
    tick(1'b1, 1'b0);

    // Reset mid-ring
    cur_alarm = cnt + 2;
    ticks(4);
    drive(1'b1, cnt, cur_alarm, 1'b0, 1'b1, 1'b0, 1'b0);
    ticks(2);

    // Hour boundary in idle
    cur_alarm = 100; cnt = 7198;
    ticks(4);

    // Random traffic
    cnt = 40000;
    for (int i = 0; i < 2500; i++) begin
      int r, present;
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 24) == 0) begin
        cur_alarm = (cnt + $urandom_range(1, 4)) % 86400;
        if (cur_alarm == 0 && $urandom_range(0, 1) == 1) cur_alarm = 86400;
      end
      cur_en  = ($urandom_range(0, 19) == 0);
      cur_arm = ($urandom_range(0, 79) != 0);
      present = cnt;
      if (cnt == 0 && $urandom_range(0, 1) == 1) present = 86400;
      drive($urandom_range(0, 299) == 0, present, cur_alarm, cur_en, cur_arm,
            $urandom_range(0, 29) == 0, $urandom_range(0, 4) == 0);
      if (r < 3)      cnt = (cnt + 60) % 86400;
      else if (r < 5) cnt = (cnt + 3600) % 86400;
      else if (r < 9) cnt = cnt;
      else            cnt = (cnt + 1) % 86400;
      if ($urandom_range(0, 199) == 0) cnt = 86396;
    end

    repeat (3) @(negedge clk_1hz);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
